loader_wr_queue: RTL and testbench

LOADER_WR_QUEUE -- requirements
Module: loader_wr_queue

---
 rtl/loader_wr_queue.sv | 126 ++++++++++++
 tb/tb_loader_wr_queue.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/loader_wr_queue.sv
// Loader write queue: buffers game-loader byte writes and issues one SDRAM write per slot window.
// Optional issued-write counter enabled by defining LOADER_WRQ_STATS_EN.
module loader_wr_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 22
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     slot,
  input  logic                     in_write,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [7:0]               in_data,
  output logic                     out_we,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [23:0]              wr_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = ADDR_W + 8;

  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;
  logic [LW-1:0] level_nxt_s;

  // Push/pop decisions; a pop needs a stored entry, so an empty queue never pops this cycle's push.
  always_comb begin
    pop_s       = 1'b0;
    push_s      = 1'b0;
    drop_s      = 1'b0;
    level_nxt_s = {LW{1'b0}};
    if (enable) begin
      pop_s  = slot && !empty;
      push_s = in_write && (!full || pop_s);
      drop_s = in_write && full && !pop_s;
      case ({push_s, pop_s})
        2'b10:   level_nxt_s = level + LW'(1);
        2'b01:   level_nxt_s = level - LW'(1);
        default: level_nxt_s = level;
      endcase
    end else begin
      level_nxt_s = {LW{1'b0}};
    end
  end

  // Entry storage; a full-queue push overwrites the slot being read this same cycle, old value is issued.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {in_addr, in_data};
    end
  end

  // Pointers, level, flags and the registered SDRAM write request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level    <= {LW{1'b0}};
      full     <= 1'b0;
      empty    <= 1'b1;
      out_we   <= 1'b0;
      out_addr <= {ADDR_W{1'b0}};
      out_data <= 8'd0;
      overflow <= 1'b0;
    end else if (!enable) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level    <= {LW{1'b0}};
      full     <= 1'b0;
      empty    <= 1'b1;
      out_we   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        out_addr <= mem_r[rd_ptr_r][EW-1:8];
        out_data <= mem_r[rd_ptr_r][7:0];
      end
      // Write request only changes at a window boundary so it spans the whole slot period.
      if (slot) begin
        out_we <= pop_s;
      end
      if (drop_s) begin
        overflow <= 1'b1;
      end
      level <= level_nxt_s;
      full  <= (level_nxt_s == LW'(DEPTH));
      empty <= (level_nxt_s == {LW{1'b0}});
    end
  end

`ifdef LOADER_WRQ_STATS_EN
  logic [23:0] wr_count_r;

  // Counts issued writes; wraps naturally at 2^24.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_count_r <= 24'd0;
    end else if (!enable) begin
      wr_count_r <= 24'd0;
    end else if (pop_s) begin
      wr_count_r <= wr_count_r + 24'd1;
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  assign wr_count = wr_count_r;
`else
  assign wr_count = 24'd0;
`endif

endmodule

// File: tb/tb_loader_wr_queue.sv
// Directed bench for loader_wr_queue with a scoreboard queue of expected SDRAM writes.
module tb_loader_wr_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        slot;
  logic        in_write;
  logic [21:0] in_addr;
  logic [7:0]  in_data;
  logic        out_we;
  logic [21:0] out_addr;
  logic [7:0]  out_data;
  logic [3:0]  level;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [23:0] wr_count;

`ifdef LOADER_WRQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  loader_wr_queue #(.DEPTH(8), .ADDR_W(22)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .slot(slot),
    .in_write(in_write), .in_addr(in_addr), .in_data(in_data),
    .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  logic [29:0] sb[$];
  logic        en = 1'b0;
  logic        exp_we = 1'b0;
  logic [21:0] exp_addr = 22'd0;
  logic [7:0]  exp_data = 8'd0;
  logic        exp_ovf = 1'b0;
  int          cnt = 0;
  int          passed = 0;
  int          total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("out_we", {31'd0, out_we}, {31'd0, exp_we});
    chk("out_addr", {10'd0, out_addr}, {10'd0, exp_addr});
    chk("out_data", {24'd0, out_data}, {24'd0, exp_data});
    chk("level", {28'd0, level}, sb.size());
    chk("full", {31'd0, full}, (sb.size() == 8) ? 32'd1 : 32'd0);
    chk("empty", {31'd0, empty}, (sb.size() == 0) ? 32'd1 : 32'd0);
    chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    chk("wr_count", {8'd0, wr_count}, STATS ? (cnt & 32'hFF_FFFF) : 32'd0);
  endtask

  // One clock: update the scoreboard for this cycle's inputs, then drive, clock and compare.
  task automatic step(input logic s, input logic w, input logic [21:0] a, input logic [7:0] d);
    logic [29:0] e;
    logic        pop_m;
    logic        push_m;
    logic        full_m;
    full_m = (sb.size() == 8);
    pop_m  = 1'b0;
    push_m = 1'b0;
    if (!en) begin
      sb.delete();
      exp_we  = 1'b0;
      exp_ovf = 1'b0;
      cnt     = 0;
    end else begin
      pop_m  = s && (sb.size() > 0);
      push_m = w && (!full_m || pop_m);
      if (pop_m) begin
        e        = sb.pop_front();
        exp_addr = e[29:8];
        exp_data = e[7:0];
        cnt++;
      end
      if (s) exp_we = pop_m;
      if (push_m) sb.push_back({a, d});
      if (w && full_m && !pop_m) exp_ovf = 1'b1;
    end
    enable   = en;
    slot     = s;
    in_write = w;
    in_addr  = a;
    in_data  = d;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 22'd0, 8'd0);
      repeat (3) step(1'b0, 1'b0, 22'd0, 8'd0);
    end
  endtask

  task automatic fill(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 22'(32'h200 + i), 8'(base + 8'(i)));
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b0;
    slot     = 1'b0;
    in_write = 1'b0;
    in_addr  = 22'd0;
    in_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    reset_n = 1'b1;

    // Single write: issued for exactly one 4-cycle window.
    en = 1'b1;
    step(1'b0, 1'b1, 22'h000010, 8'hA5);
    frames(2);

    // Burst of 8 fills the queue, drains in order.
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, 22'(32'h100 + i), 8'(i));
    chk("burst_full", {31'd0, full}, 32'd1);
    frames(9);

    // Overflow: ninth write dropped and never issued.
    fill(8, 8'h10);
    step(1'b0, 1'b1, 22'h3FFFFF, 8'hEE);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    frames(9);

    // Simultaneous push and pop on a full queue.
    en = 1'b0;
    step(1'b0, 1'b0, 22'd0, 8'd0);
    en = 1'b1;
    fill(8, 8'h20);
    step(1'b1, 1'b1, 22'h000099, 8'h99);
    chk("simul_level", {28'd0, level}, 32'd8);
    repeat (3) step(1'b0, 1'b0, 22'd0, 8'd0);
    frames(9);

    // Flush mid-window with five entries left, then resume.
    fill(6, 8'h30);
    frames(1);
    chk("pre_flush_level", {28'd0, level}, 32'd5);
    en = 1'b0;
    step(1'b0, 1'b0, 22'd0, 8'd0);
    step(1'b1, 1'b1, 22'h000055, 8'h55);
    en = 1'b1;
    step(1'b0, 1'b1, 22'h000042, 8'h42);
    frames(2);

    // Push and slot together on an empty queue waits for the following slot.
    step(1'b1, 1'b1, 22'h000077, 8'h77);
    chk("same_cycle_we", {31'd0, out_we}, 32'd0);
    repeat (3) step(1'b0, 1'b0, 22'd0, 8'd0);
    frames(2);

    // Stats: 300 issued writes, then flush clears the counter.
    en = 1'b0;
    step(1'b0, 1'b0, 22'd0, 8'd0);
    en = 1'b1;
    step(1'b0, 1'b1, 22'h001000, 8'h00);
    for (int i = 1; i <= 300; i++) begin
      step(1'b1, 1'b1, 22'(32'h1000 + i), 8'(i));
      repeat (3) step(1'b0, 1'b0, 22'd0, 8'd0);
    end
    chk("stats300", {8'd0, wr_count}, STATS ? 32'd300 : 32'd0);
    en = 1'b0;
    step(1'b0, 1'b0, 22'd0, 8'd0);
    chk("stats_clear", {8'd0, wr_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
